// File: rtl/ppm_sof_detector.sv
// ppm_sof_detector: PPM start-of-frame detector on the 16x oversampling clock.
// An SOF is two active-low pulses, each of acceptable length, whose leading
// edges are SOF_SPACING +/- TOL samples apart. Emits sof_rcv / sof_err strobes,
// the measured spacing of the last good SOF and a saturating SOF count.
// Optional build macro: SOF_MAJ_FILTER_EN adds a 3-sample majority filter on
// the synchronised line (one extra cycle of latency, 1-sample glitches removed).
module ppm_sof_detector #(
  parameter int PULSE_MIN   = 4,
  parameter int PULSE_MAX   = 12,
  parameter int SOF_SPACING = 80,
  parameter int TOL         = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk16,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic             sof_rcv,
  output logic             sof_err,
  output logic             busy,
  output logic [CNT_W-1:0] sof_spacing,
  output logic [7:0]       sof_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P1      = 3'd1,
    GAP     = 3'd2,
    P2      = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  // All limits are carried at the counter width so every decision is a
  // plain CNT_W-bit unsigned compare.
  localparam logic [CNT_W-1:0] LEN_MIN  = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] LEN_OVR  = CNT_W'(PULSE_MAX + 1);
  localparam logic [CNT_W-1:0] SP_LO    = CNT_W'(SOF_SPACING - TOL);
  localparam logic [CNT_W-1:0] SP_HI    = CNT_W'(SOF_SPACING + TOL);
  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state, state_n;

  logic             sync1, sync2;
  logic             s_raw, s, s_d;
  logic             fall, rise;
  logic [CNT_W-1:0] len, sp, sp_cap;
  logic [CNT_W-1:0] len_inc, sp_inc;
  logic             too_long, len_ok;
  logic             sp_early, sp_late;

  // control from the output decoder
  logic ld_start, ld_len1, inc_len, inc_sp, cap_sp;
  logic rcv_d, err_d;

  // ---------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk16) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // s = 1 means the line is low (pulse active).
  assign s_raw = ~sync2;

`ifdef SOF_MAJ_FILTER_EN
  logic s_h1, s_h2;

  // History of the last two raw samples for the majority vote.
  always_ff @(posedge clk16) begin
    if (rst) begin
      s_h1 <= 1'b0;
      s_h2 <= 1'b0;
    end else begin
      s_h1 <= s_raw;
      s_h2 <= s_h1;
    end
  end

  // 2-of-3 vote: both edges move one cycle later, so lengths are preserved
  // while isolated single-sample flips are dropped.
  assign s = (s_raw & s_h1) | (s_raw & s_h2) | (s_h1 & s_h2);
`else
  assign s = s_raw;
`endif

  // One-sample delay of the (possibly filtered) line for edge detection.
  always_ff @(posedge clk16) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

  assign fall = s & ~s_d;
  assign rise = ~s & s_d;

  // ---------------------------------------------------------------------
  // Counter arithmetic and decisions
  // ---------------------------------------------------------------------

  assign len_inc  = (len == CNT_ONES) ? len : len + CNT_ONE;
  assign sp_inc   = (sp  == CNT_ONES) ? sp  : sp  + CNT_ONE;

  // len holds the low samples seen before this cycle; this cycle's low
  // sample would push it past PULSE_MAX.
  assign too_long = s & (len_inc == LEN_OVR);
  // Evaluated on rise: len is then the full pulse length.
  assign len_ok   = (len >= LEN_MIN);

  assign sp_early = (sp < SP_LO);
  assign sp_late  = (sp > SP_HI);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk16) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; dropping en forces IDLE on the next cycle.
  always_comb begin
    state_n = state;
    if (!en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fall) state_n = P1;
        end
        P1, P2: begin
          if (rise)          state_n = (state == P1 && len_ok) ? GAP : IDLE;
          else if (too_long) state_n = WAIT_HI;
        end
        GAP: begin
          // A fall arriving in the same cycle as the timeout is too late.
          if (sp_late)   state_n = IDLE;
          else if (fall) state_n = sp_early ? P1 : P2;
        end
        WAIT_HI: begin
          if (rise) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output / datapath-control decode; all strobes suppressed while disabled.
  always_comb begin
    ld_start = 1'b0;
    ld_len1  = 1'b0;
    inc_len  = 1'b0;
    inc_sp   = 1'b0;
    cap_sp   = 1'b0;
    rcv_d    = 1'b0;
    err_d    = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          ld_start = fall;
        end
        P1: begin
          inc_len = 1'b1;
          inc_sp  = 1'b1;
          err_d   = ~rise & too_long;
        end
        GAP: begin
          inc_sp = 1'b1;
          if (sp_late) begin
            err_d = 1'b1;
          end else if (fall) begin
            if (sp_early) begin
              // Second edge came too soon: treat it as a fresh first pulse.
              err_d    = 1'b1;
              ld_start = 1'b1;
            end else begin
              ld_len1 = 1'b1;
              cap_sp  = 1'b1;
            end
          end
        end
        P2: begin
          inc_len = 1'b1;
          inc_sp  = 1'b1;
          if (rise) begin
            rcv_d = len_ok;
            err_d = ~len_ok;
          end else begin
            err_d = too_long;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------

  // Pulse-length and edge-spacing counters, cleared while disabled.
  always_ff @(posedge clk16) begin
    if (rst || !en) begin
      len    <= '0;
      sp     <= '0;
      sp_cap <= '0;
    end else begin
      if (ld_start) begin
        len <= CNT_ONE;
        sp  <= CNT_ONE;
      end else begin
        if (ld_len1)      len <= CNT_ONE;
        else if (inc_len) len <= len_inc;
        if (inc_sp)       sp  <= sp_inc;
      end
      // Spacing is latched at the second fall but only published once the
      // second pulse proves valid.
      if (cap_sp) sp_cap <= sp;
    end
  end

  // Registered strobes, published spacing and saturating SOF count.
  always_ff @(posedge clk16) begin
    if (rst) begin
      sof_rcv     <= 1'b0;
      sof_err     <= 1'b0;
      sof_spacing <= '0;
      sof_count   <= 8'd0;
    end else begin
      sof_rcv <= rcv_d;
      sof_err <= err_d;
      if (rcv_d) begin
        sof_spacing <= sp_cap;
        if (sof_count != 8'hFF) sof_count <= sof_count + 8'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ppm_sof_detector.sv
// Directed bench for ppm_sof_detector with default parameters.
module tb_ppm_sof_detector;

`ifdef SOF_MAJ_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       clk16 = 1'b0;
  logic       rst, en, din;
  logic       sof_rcv, sof_err, busy;
  logic [7:0] sof_spacing;
  logic [7:0] sof_count;

  int cyc     = 0;
  int n_rcv   = 0;
  int n_err   = 0;
  int n_both  = 0;
  int rcv_cyc = -1;
  int n_chk   = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int n_hi, r0, e0;

  ppm_sof_detector dut (
    .clk16      (clk16),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .sof_rcv    (sof_rcv),
    .sof_err    (sof_err),
    .busy       (busy),
    .sof_spacing(sof_spacing),
    .sof_count  (sof_count)
  );

  always #5 clk16 = ~clk16;

  always @(posedge clk16) cyc <= cyc + 1;

  // strobe recorder, sampled mid-cycle
  always @(negedge clk16) begin
    if (sof_rcv) begin
      n_rcv   <= n_rcv + 1;
      rcv_cyc <= cyc;
    end
    if (sof_err) n_err <= n_err + 1;
    if (sof_rcv && sof_err) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // hold din at v for n cycles; returns #1 after the n-th edge
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      din = v;
      @(posedge clk16);
      #1;
    end
  endtask

  // low l1, leading edges spc apart, low l2; n_out = first high cycle after
  task automatic frame(input int l1, input int spc, input int l2, output int n_out);
    drive(1'b0, l1);
    drive(1'b1, spc - l1);
    drive(1'b0, l2);
    n_out = cyc;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; din = 1'b1;
    repeat (3) @(posedge clk16);
    #1;
    chk("rst_rcv",     sof_rcv,     0);
    chk("rst_err",     sof_err,     0);
    chk("rst_busy",    busy,        0);
    chk("rst_spacing", sof_spacing, 0);
    chk("rst_count",   sof_count,   0);
    rst = 1'b0;
    drive(1'b1, 5);

    // nominal spacing 80
    r0 = n_rcv; e0 = n_err;
    frame(8, 80, 8, n_hi);
    drive(1'b1, 20);
    chk("f80_rcv_n",   n_rcv - r0,  1);
    chk("f80_rcv_cyc", rcv_cyc,     n_hi + LAT);
    chk("f80_spacing", sof_spacing, 80);
    chk("f80_count",   sof_count,   1);
    chk("f80_err",     n_err - e0,  0);

    // tolerance limits
    r0 = n_rcv;
    frame(8, 76, 8, n_hi);
    drive(1'b1, 20);
    chk("f76_rcv_cyc", rcv_cyc,     n_hi + LAT);
    chk("f76_spacing", sof_spacing, 76);
    frame(8, 84, 8, n_hi);
    drive(1'b1, 20);
    chk("f84_rcv_cyc", rcv_cyc,     n_hi + LAT);
    chk("f84_spacing", sof_spacing, 84);
    chk("f76_84_rcv_n", n_rcv - r0, 2);
    chk("f84_count",   sof_count,   3);

    // spacing 75: early error, restart in P1, then GAP timeout
    r0 = n_rcv; e0 = n_err;
    frame(8, 75, 8, n_hi);
    chk("f75_err_early", n_err - e0, 1);
    chk("f75_busy",      busy,       1);
    drive(1'b1, 100);
    chk("f75_err_total", n_err - e0, 2);
    chk("f75_idle",      busy,       0);
    chk("f75_rcv_n",     n_rcv - r0, 0);

    // spacing 85: timeout error, back to IDLE
    r0 = n_rcv; e0 = n_err;
    frame(8, 85, 8, n_hi);
    drive(1'b1, 30);
    chk("f85_err",   n_err - e0, 1);
    chk("f85_rcv_n", n_rcv - r0, 0);
    chk("f85_idle",  busy,       0);
    chk("f85_spacing_held", sof_spacing, 84);

    // 3-sample glitch: silent return to IDLE
    r0 = n_rcv; e0 = n_err;
    drive(1'b0, 3);
    chk("p3_busy", busy, 1);
    drive(1'b1, 6);
    chk("p3_idle",  busy,       0);
    chk("p3_err",   n_err - e0, 0);
    chk("p3_rcv_n", n_rcv - r0, 0);

    // over-long first pulse: one error, busy until the line rises
    e0 = n_err;
    drive(1'b0, 20);
    chk("p13_err",  n_err - e0, 1);
    chk("p13_busy", busy,       1);
    drive(1'b1, 6);
    chk("p13_idle",     busy,       0);
    chk("p13_err_once", n_err - e0, 1);

    // en dropped during GAP
    r0 = n_rcv;
    drive(1'b0, 8);
    drive(1'b1, 20);
    chk("en_gap_busy", busy, 1);
    en = 1'b0;
    drive(1'b1, 1);
    chk("en_off_idle", busy, 0);
    en = 1'b1;
    drive(1'b1, 80 - 29);
    drive(1'b0, 8);
    drive(1'b1, 100);
    chk("en_rcv_n", n_rcv - r0, 0);
    chk("en_count", sof_count,  3);

    // count saturation
    r0 = n_rcv;
    for (int k = 0; k < 260; k++) begin
      frame(4, 80, 4, n_hi);
      drive(1'b1, 4);
    end
    drive(1'b1, 10);
    chk("sat_rcv_n", n_rcv - r0, 260);
    chk("sat_count", sof_count,  255);

    // 1-sample high glitch inside the first pulse
    r0 = n_rcv; e0 = n_err;
    drive(1'b0, 5);
    drive(1'b1, 1);
    drive(1'b0, 3);
    drive(1'b1, 80 - 9);
    drive(1'b0, 8);
    n_hi = cyc;
    drive(1'b1, 100);
`ifdef SOF_MAJ_FILTER_EN
    chk("glitch_rcv_n",   n_rcv - r0, 1);
    chk("glitch_rcv_cyc", rcv_cyc,    n_hi + LAT);
    chk("glitch_spacing", sof_spacing, 80);
    chk("glitch_err",     n_err - e0, 0);
`else
    chk("glitch_rcv_n",   n_rcv - r0, 0);
    chk("glitch_err",     n_err - e0, 2);
`endif
    chk("glitch_count", sof_count, 255);

    // reset during P2
    r0 = n_rcv; e0 = n_err;
    drive(1'b0, 8);
    drive(1'b1, 72);
    drive(1'b0, 4);
    chk("p2_busy", busy, 1);
    rst = 1'b1; din = 1'b1;
    @(posedge clk16);
    #1;
    chk("p2rst_rcv",     sof_rcv,     0);
    chk("p2rst_err",     sof_err,     0);
    chk("p2rst_busy",    busy,        0);
    chk("p2rst_spacing", sof_spacing, 0);
    chk("p2rst_count",   sof_count,   0);
    rst = 1'b0;
    drive(1'b1, 50);
    chk("p2rst_rcv_n", n_rcv - r0, 0);
    chk("p2rst_err_n", n_err - e0, 0);

    chk("strobes_exclusive", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
